salamander_prom_loader: RTL and testbench

- Writer side of the PROM programming port: converts the HPS ioctl download byte stream into per-PROM program writes (address, data, chip select, write strobe).
- Sits between the top-level ioctl interface and up to NREG byte-wide PROM instances (colour/sprite lookup PROMs). Handles region decode, write-strobe timing and download-complete signalling.

---
 rtl/salamander_prom_loader_pkg.sv | 14 +
 rtl/salamander_prom_loader_if.sv | 40 ++++
 rtl/salamander_prom_region_decode.sv | 37 +++
 rtl/salamander_prom_loader.sv | 195 +++++++++++++++++++
 tb/tb_salamander_prom_loader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/salamander_prom_loader_pkg.sv
// Shared definitions for the Salamander PROM loader.
// Contents:
//   IoctlAw - width of the HPS ioctl byte address.
//   StIdle, StDecode, StStrobe, StRelease - loader FSM state encoding.
package salamander_prom_loader_pkg;

    localparam int unsigned IoctlAw = 25;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StDecode  = 2'd1;
    localparam logic [1:0] StStrobe  = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

endpackage

// File: rtl/salamander_prom_loader_if.sv
// ioctl download port plus PROM program port of the Salamander PROM loader.
// Signals:
//   i_IOCTL_DOWNLOAD/INDEX/WR/ADDR/DATA - HPS download stream (into the loader)
//   o_IOCTL_WAIT                        - back-pressure to the HPS
//   o_PROG_ADDR/DIN/CS/WR               - PROM program write port
//   o_LOADED, o_DONE, o_CHECKSUM        - download status
// Modports: master = HPS / system side, slave = loader.
interface salamander_prom_loader_if
    import salamander_prom_loader_pkg::*;
#(
    parameter int unsigned AW   = 10,
    parameter int unsigned NREG = 4
);
    logic               i_IOCTL_DOWNLOAD;
    logic [7:0]         i_IOCTL_INDEX;
    logic               i_IOCTL_WR;
    logic [IoctlAw-1:0] i_IOCTL_ADDR;
    logic [7:0]         i_IOCTL_DATA;
    logic               o_IOCTL_WAIT;
    logic [AW-1:0]      o_PROG_ADDR;
    logic [7:0]         o_PROG_DIN;
    logic [NREG-1:0]    o_PROG_CS;
    logic               o_PROG_WR;
    logic               o_LOADED;
    logic               o_DONE;
    logic [15:0]        o_CHECKSUM;

    modport master (
        output i_IOCTL_DOWNLOAD, i_IOCTL_INDEX, i_IOCTL_WR, i_IOCTL_ADDR, i_IOCTL_DATA,
        input  o_IOCTL_WAIT, o_PROG_ADDR, o_PROG_DIN, o_PROG_CS, o_PROG_WR,
        input  o_LOADED, o_DONE, o_CHECKSUM
    );

    modport slave (
        input  i_IOCTL_DOWNLOAD, i_IOCTL_INDEX, i_IOCTL_WR, i_IOCTL_ADDR, i_IOCTL_DATA,
        output o_IOCTL_WAIT, o_PROG_ADDR, o_PROG_DIN, o_PROG_CS, o_PROG_WR,
        output o_LOADED, o_DONE, o_CHECKSUM
    );

endinterface

// File: rtl/salamander_prom_region_decode.sv
// Combinational region decoder: maps a download byte address onto one of NREG
// contiguous regions of 2**AW bytes starting at BASE.
// Ports:
//   addr - download byte address
//   hit  - address falls inside one of the regions
//   cs   - one-hot region select (all zero on a miss)
//   off  - byte offset inside the selected region
module salamander_prom_region_decode
    import salamander_prom_loader_pkg::*;
#(
    parameter int unsigned        AW   = 10,
    parameter int unsigned        NREG = 4,
    parameter logic [IoctlAw-1:0] BASE = 25'h30000
) (
    input  logic [IoctlAw-1:0] addr,
    output logic               hit,
    output logic [NREG-1:0]    cs,
    output logic [AW-1:0]      off
);
    localparam logic [IoctlAw-1:0] Span = IoctlAw'(NREG) << AW;

    logic [IoctlAw-1:0] diff;
    logic [IoctlAw-1:0] region;

    always_comb begin
        // Wraps modulo 2**25; the explicit >= BASE test stops low addresses aliasing in.
        diff   = addr - BASE;
        hit    = (addr >= BASE) && (diff < Span);
        region = diff >> AW;
        off    = diff[AW-1:0];
        cs     = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cs[i] = hit && (region == IoctlAw'(i));
        end
    end

endmodule

// File: rtl/salamander_prom_loader.sv
// Salamander PROM loader: turns the HPS ioctl download byte stream into
// per-PROM program writes with region decode, write-strobe timing and
// download-complete signalling.
// Ports:
//   i_MCLK  - system clock
//   i_RST_n - asynchronous active-low reset
//   bus     - salamander_prom_loader_if.slave (ioctl in, PROM program out, status)
// Build option: define SALAMANDER_PROM_LOADER_CHECKSUM_EN to build the byte-sum
// checksum on o_CHECKSUM; otherwise o_CHECKSUM is tied to zero.
module salamander_prom_loader
    import salamander_prom_loader_pkg::*;
#(
    parameter int unsigned        AW        = 10,
    parameter int unsigned        NREG      = 4,
    parameter logic [IoctlAw-1:0] ROM_BASE  = 25'h30000,
    parameter logic [7:0]         ROM_INDEX = 8'd0,
    parameter int unsigned        WR_CYC    = 2
) (
    input logic                     i_MCLK,
    input logic                     i_RST_n,
    salamander_prom_loader_if.slave bus
);
    logic [1:0]         state_q, state_d;
    logic [IoctlAw-1:0] addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wait_q, wait_d;
    logic [NREG-1:0]    cs_q, cs_d;
    logic [AW-1:0]      paddr_q, paddr_d;
    logic [7:0]         din_q, din_d;
    logic               wr_q, wr_d;
    logic               loaded_q, loaded_d;
    logic               done_q, done_d;
    logic               dl_q;
    logic               match_q, match_d;  // index matched at the last download rise
    logic               pend_q, pend_d;    // download ended, completion not yet reported
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
    logic [15:0]        sum_q, sum_d;
`endif

    logic            dec_hit;
    logic [NREG-1:0] dec_cs;
    logic [AW-1:0]   dec_off;
    logic            idx_ok, dl_rise, dl_fall, accept;

    salamander_prom_region_decode #(
        .AW   (AW),
        .NREG (NREG),
        .BASE (ROM_BASE)
    ) u_decode (
        .addr (addr_q),
        .hit  (dec_hit),
        .cs   (dec_cs),
        .off  (dec_off)
    );

    assign idx_ok  = (bus.i_IOCTL_INDEX == ROM_INDEX);
    assign dl_rise = bus.i_IOCTL_DOWNLOAD & ~dl_q;
    assign dl_fall = ~bus.i_IOCTL_DOWNLOAD & dl_q;
    assign accept  = bus.i_IOCTL_DOWNLOAD & bus.i_IOCTL_WR & idx_ok & ~wait_q &
                     (state_q == StIdle);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        cs_d     = cs_q;
        paddr_d  = paddr_q;
        din_d    = din_q;
        wr_d     = wr_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        match_d  = match_q;
        pend_d   = pend_q;
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif

        if (dl_rise) begin
            match_d = idx_ok;
            if (idx_ok) begin
                loaded_d = 1'b0;
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
                sum_d    = '0;
`endif
            end
        end

        unique case (state_q)
            StIdle: begin
                // Completion is reported only from idle so an in-flight write finishes first.
                if (pend_q) begin
                    loaded_d = 1'b1;
                    done_d   = 1'b1;
                    pend_d   = 1'b0;
                end
                if (accept) begin
                    addr_d  = bus.i_IOCTL_ADDR;
                    data_d  = bus.i_IOCTL_DATA;
                    wait_d  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_hit) begin
                    cs_d    = dec_cs;
                    paddr_d = dec_off;
                    din_d   = data_q;
                    wr_d    = 1'b1;
                    cnt_d   = 4'(WR_CYC - 1);
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
                    sum_d   = sum_d + {8'h00, data_q};
`endif
                    state_d = StStrobe;
                end else begin
                    state_d = StRelease;
                end
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    wr_d    = 1'b0;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRelease: begin
                cs_d    = '0;
                wr_d    = 1'b0;
                wait_d  = 1'b0;
                state_d = StIdle;
            end
        endcase

        if (dl_fall && match_q) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            wait_q   <= 1'b0;
            cs_q     <= '0;
            paddr_q  <= '0;
            din_q    <= '0;
            wr_q     <= 1'b0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            dl_q     <= 1'b0;
            match_q  <= 1'b0;
            pend_q   <= 1'b0;
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            cs_q     <= cs_d;
            paddr_q  <= paddr_d;
            din_q    <= din_d;
            wr_q     <= wr_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            dl_q     <= bus.i_IOCTL_DOWNLOAD;
            match_q  <= match_d;
            pend_q   <= pend_d;
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign bus.o_IOCTL_WAIT = wait_q;
    assign bus.o_PROG_ADDR  = paddr_q;
    assign bus.o_PROG_DIN   = din_q;
    assign bus.o_PROG_CS    = cs_q;
    assign bus.o_PROG_WR    = wr_q;
    assign bus.o_LOADED     = loaded_q;
    assign bus.o_DONE       = done_q;
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
    assign bus.o_CHECKSUM   = sum_q;
`else
    assign bus.o_CHECKSUM   = 16'h0000;
`endif

endmodule

// File: tb/tb_salamander_prom_loader.sv
// Scoreboard bench for salamander_prom_loader: the driver pushes expected PROM
// writes and done pulses computed from address arithmetic; a monitor pops and
// compares whenever the DUT strobes o_PROG_WR or o_DONE.
module tb_salamander_prom_loader;

    localparam int BASE   = 'h30000;
    localparam int SPAN   = 4096;
    localparam int RSIZE  = 1024;
    localparam int WR_CYC = 2;

    typedef struct packed {
        logic [3:0] cs;
        logic [9:0] pa;
        logic [7:0] din;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    salamander_prom_loader_if #(.AW(10), .NREG(4)) bus ();

    salamander_prom_loader #(
        .AW        (10),
        .NREG      (4),
        .ROM_BASE  (25'h30000),
        .ROM_INDEX (8'd0),
        .WR_CYC    (WR_CYC)
    ) dut (
        .i_MCLK  (clk),
        .i_RST_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          done_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          dl_model = 1'b0;
    logic [15:0] sum_model = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] exp_sum();
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
        return sum_model;
`else
        return 16'h0000;
`endif
    endfunction

    // One ioctl write; returns after o_IOCTL_WAIT drops (bounded).
    task automatic do_write(input int a, input logic [7:0] d, input logic [7:0] idx,
                            input bit drop);
        bit   acc, hit, cs_any;
        int   occ, n;
        exp_t e;
        acc = dl_model && (idx == 8'd0);
        hit = acc && (a >= BASE) && (a - BASE < SPAN);
        if (hit) begin
            e.cs  = 4'(1 << ((a - BASE) / RSIZE));
            e.pa  = 10'((a - BASE) % RSIZE);
            e.din = d;
            exp_q.push_back(e);
            sum_model = sum_model + 16'(d);
        end
        occ = !acc ? 0 : (hit ? 2 + WR_CYC : 2);
        @(negedge clk);
        bus.i_IOCTL_WR    = 1'b1;
        bus.i_IOCTL_ADDR  = 25'(a);
        bus.i_IOCTL_DATA  = d;
        bus.i_IOCTL_INDEX = idx;
        @(negedge clk);
        bus.i_IOCTL_WR = 1'b0;
        if (drop) begin
            bus.i_IOCTL_DOWNLOAD = 1'b0;
            dl_model = 1'b0;
            done_q.push_back(1);
        end
        n = 0;
        cs_any = 1'b0;
        while (bus.o_IOCTL_WAIT && n < 64) begin
            cs_any |= (bus.o_PROG_CS != 4'h0);
            n++;
            @(negedge clk);
        end
        check("wait_occupancy", 32'(n), 32'(occ));
        if (!hit) check("miss_cs_idle", 32'(cs_any), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_q.size() != 0 && n < 32) begin
            n++;
            @(negedge clk);
        end
        check("done_seen", 32'(done_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic raise(input logic [7:0] idx);
        @(negedge clk);
        bus.i_IOCTL_INDEX    = idx;
        bus.i_IOCTL_DOWNLOAD = 1'b1;
        dl_model = 1'b1;
        if (idx == 8'd0) sum_model = 16'h0;
        @(negedge clk);
    endtask

    // Monitor: compares every program strobe and done pulse against the queues.
    initial begin : monitor
        exp_t cur, e;
        int   len;
        bit   active, unstable;
        active = 1'b0;
        len = 0;
        unstable = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else begin
                if (bus.o_PROG_WR) begin
                    if (!active) begin
                        active = 1'b1;
                        len = 1;
                        unstable = 1'b0;
                        cur = {bus.o_PROG_CS, bus.o_PROG_ADDR, bus.o_PROG_DIN};
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_wr: actual strobe cs=0x%0h addr=0x%0h required none",
                                     bus.o_PROG_CS, bus.o_PROG_ADDR);
                        end else begin
                            e = exp_q.pop_front();
                            check("prog_cs", 32'(bus.o_PROG_CS), 32'(e.cs));
                            check("prog_addr", 32'(bus.o_PROG_ADDR), 32'(e.pa));
                            check("prog_din", 32'(bus.o_PROG_DIN), 32'(e.din));
                        end
                    end else begin
                        len++;
                        if ({bus.o_PROG_CS, bus.o_PROG_ADDR, bus.o_PROG_DIN} != cur) unstable = 1'b1;
                    end
                end else if (active) begin
                    active = 1'b0;
                    check("wr_length", 32'(len), 32'(WR_CYC));
                    check("strobe_stable", 32'(unstable), 32'd0);
                end
                if (bus.o_DONE) begin
                    if (done_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: actual pulse required none");
                    end else begin
                        void'(done_q.pop_front());
                        check("done_after_write", 32'({bus.o_PROG_WR, bus.o_IOCTL_WAIT}), 32'd0);
                    end
                end
            end
        end
    end

    initial begin : driver
        int   a, n;
        exp_t e;
        bus.i_IOCTL_DOWNLOAD = 1'b0;
        bus.i_IOCTL_INDEX    = 8'd0;
        bus.i_IOCTL_WR       = 1'b0;
        bus.i_IOCTL_ADDR     = '0;
        bus.i_IOCTL_DATA     = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_wait", 32'(bus.o_IOCTL_WAIT), 32'd0);
        check("rst_prog_addr", 32'(bus.o_PROG_ADDR), 32'd0);
        check("rst_prog_din", 32'(bus.o_PROG_DIN), 32'd0);
        check("rst_prog_cs", 32'(bus.o_PROG_CS), 32'd0);
        check("rst_prog_wr", 32'(bus.o_PROG_WR), 32'd0);
        check("rst_loaded", 32'(bus.o_LOADED), 32'd0);
        check("rst_done", 32'(bus.o_DONE), 32'd0);
        check("rst_checksum", 32'(bus.o_CHECKSUM), 32'd0);
        rst_n = 1'b1;

        raise(8'd0);
        check("loaded_after_rise", 32'(bus.o_LOADED), 32'd0);
        do_write('h30010, 8'hFF, 8'd0, 1'b0);
        do_write('h30011, 8'h02, 8'd0, 1'b0);
`ifdef SALAMANDER_PROM_LOADER_CHECKSUM_EN
        check("checksum_ff_02", 32'(bus.o_CHECKSUM), 32'h0101);
`else
        check("checksum_off", 32'(bus.o_CHECKSUM), 32'h0);
`endif
        do_write('h30005, 8'hA5, 8'd0, 1'b0);
        do_write('h30FFF, 8'h3C, 8'd0, 1'b0);
        do_write('h2FFFF, 8'h11, 8'd0, 1'b0);
        do_write('h31000, 8'h22, 8'd0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: a = int'($urandom_range(BASE - 16, BASE + 16));
                1: a = int'($urandom_range(BASE + SPAN - 16, BASE + SPAN + 16));
                2: a = int'($urandom & 32'h01FF_FFFF);
                default: a = int'($urandom_range(BASE, BASE + SPAN - 1));
            endcase
            do_write(a, 8'($urandom),
                     ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0, 1'b0);
        end
        check("checksum_random", 32'(bus.o_CHECKSUM), 32'(exp_sum()));

        // Full image, download dropped while the last byte is still being written.
        for (int i = 0; i < SPAN; i++) begin
            do_write(BASE + i, 8'($urandom), 8'd0, i == SPAN - 1);
        end
        wait_done();
        check("loaded_after_end", 32'(bus.o_LOADED), 32'd1);
        check("checksum_image", 32'(bus.o_CHECKSUM), 32'(exp_sum()));

        raise(8'd0);
        check("loaded_cleared", 32'(bus.o_LOADED), 32'd0);
        @(negedge clk);
        bus.i_IOCTL_DOWNLOAD = 1'b0;
        dl_model = 1'b0;
        done_q.push_back(1);
        wait_done();
        check("loaded_empty_dl", 32'(bus.o_LOADED), 32'd1);

        // Non-matching rise leaves o_LOADED alone; reset then aborts a live strobe.
        raise(8'd1);
        check("loaded_kept", 32'(bus.o_LOADED), 32'd1);
        do_write('h30020, 8'h11, 8'd1, 1'b0);
        e.cs = 4'b0001;
        e.pa = 10'h100;
        e.din = 8'h5A;
        exp_q.push_back(e);
        @(negedge clk);
        bus.i_IOCTL_WR    = 1'b1;
        bus.i_IOCTL_ADDR  = 25'h30100;
        bus.i_IOCTL_DATA  = 8'h5A;
        bus.i_IOCTL_INDEX = 8'd0;
        @(negedge clk);
        bus.i_IOCTL_WR = 1'b0;
        n = 0;
        while (!bus.o_PROG_WR && n < 16) begin
            n++;
            @(negedge clk);
        end
        check("strobe_before_reset", 32'(bus.o_PROG_WR), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wr", 32'(bus.o_PROG_WR), 32'd0);
        check("async_rst_cs", 32'(bus.o_PROG_CS), 32'd0);
        check("async_rst_wait", 32'(bus.o_IOCTL_WAIT), 32'd0);
        check("async_rst_loaded", 32'(bus.o_LOADED), 32'd0);
        check("async_rst_checksum", 32'(bus.o_CHECKSUM), 32'd0);
        exp_q.delete();
        sum_model = 16'h0;
        @(negedge clk);
        bus.i_IOCTL_DOWNLOAD = 1'b0;
        dl_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Wrong index: no back-pressure, no strobe, no done.
        raise(8'd1);
        do_write('h30005, 8'h77, 8'd1, 1'b0);
        @(negedge clk);
        bus.i_IOCTL_DOWNLOAD = 1'b0;
        dl_model = 1'b0;
        repeat (20) @(negedge clk);
        check("loaded_wrong_idx", 32'(bus.o_LOADED), 32'd0);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
